// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: opcodes, control bundle widths and bit positions.
// Control bundle layout: wb={RegWrite,MemtoReg}, m={Branch,MemRead,MemWrite}, ex={RegDst,ALUOp[1:0],ALUSrc}.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam int M_BRANCH   = 2;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 0;

    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
    } ctl_t;

endpackage

// File: rtl/id_regfile.sv
// Register file for the decode stage: two combinational read ports, one write port, r0 hardwired to zero.
// Build option REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module id_regfile #(
    parameter int NREGS = 32,
    parameter int DW    = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2
);

    logic [DW-1:0] regs_q [NREGS];
    logic [DW-1:0] regs_d [NREGS];
    logic          wr_en;

    assign wr_en = we && (wa != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en)
            regs_d[wa] = wd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
        rd2 = (ra2 == '0) ? '0 : regs_q[ra2];
`ifdef REGFILE_BYPASS_EN
        // wr_en already excludes r0, so the zero rule survives forwarding
        if (wr_en && (wa == ra1))
            rd1 = wd;
        if (wr_en && (wa == ra2))
            rd2 = wd;
`endif
    end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction decode stage: control decode, register read, sign extension, ID/EX latch.
// Optional build macro REGFILE_BYPASS_EN enables write-to-read forwarding in the register file.
module id_stage
    import mips_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int DW    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     if_id_instr,
    input  logic [31:0]     if_id_npc,
    input  logic            stall,
    input  logic            flush,
    input  logic            mem_wb_regwrite,
    input  logic [4:0]      mem_wb_writereg,
    input  logic [DW-1:0]   wb_writedata,
    output logic [WB_W-1:0] id_ex_wb,
    output logic [M_W-1:0]  id_ex_m,
    output logic [EX_W-1:0] id_ex_ex,
    output logic [31:0]     id_ex_npc,
    output logic [DW-1:0]   id_ex_readdat1,
    output logic [DW-1:0]   id_ex_readdat2,
    output logic [31:0]     id_ex_sign_ext,
    output logic [4:0]      id_ex_instr_2016,
    output logic [4:0]      id_ex_instr_1511
);

    logic [DW-1:0] rd1, rd2;
    ctl_t          dec_ctl;

    ctl_t          ctl_q,  ctl_d;
    logic [31:0]   npc_q,  npc_d;
    logic [DW-1:0] rdat1_q, rdat1_d;
    logic [DW-1:0] rdat2_q, rdat2_d;
    logic [31:0]   sext_q, sext_d;
    logic [4:0]    rt_q,   rt_d;
    logic [4:0]    rd_q,   rd_d;

    id_regfile #(.NREGS(NREGS), .DW(DW)) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (if_id_instr[25:21]),
        .ra2 (if_id_instr[20:16]),
        .we  (mem_wb_regwrite),
        .wa  (mem_wb_writereg),
        .wd  (wb_writedata),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    always_comb begin
        dec_ctl = '0;
        unique case (if_id_instr[31:26])
            OP_RTYPE: begin
                dec_ctl.wb[WB_REGWRITE] = 1'b1;
                dec_ctl.ex[EX_REGDST]   = 1'b1;
                dec_ctl.ex[EX_ALUOP_HI] = 1'b1;
            end
            OP_LW: begin
                dec_ctl.wb[WB_REGWRITE] = 1'b1;
                dec_ctl.wb[WB_MEMTOREG] = 1'b1;
                dec_ctl.m[M_MEMREAD]    = 1'b1;
                dec_ctl.ex[EX_ALUSRC]   = 1'b1;
            end
            OP_SW: begin
                dec_ctl.m[M_MEMWRITE]   = 1'b1;
                dec_ctl.ex[EX_ALUSRC]   = 1'b1;
            end
            OP_BEQ: begin
                dec_ctl.m[M_BRANCH]     = 1'b1;
                dec_ctl.ex[EX_ALUOP_LO] = 1'b1;
            end
            default: dec_ctl = '0;
        endcase
    end

    // flush outranks stall: a bubble is loaded even while hazard logic asks to hold
    always_comb begin
        ctl_d   = ctl_q;
        npc_d   = npc_q;
        rdat1_d = rdat1_q;
        rdat2_d = rdat2_q;
        sext_d  = sext_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        if (flush || !stall) begin
            ctl_d   = flush ? '0 : dec_ctl;
            npc_d   = if_id_npc;
            rdat1_d = rd1;
            rdat2_d = rd2;
            sext_d  = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
            rt_d    = if_id_instr[20:16];
            rd_d    = if_id_instr[15:11];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_q   <= '0;
            npc_q   <= '0;
            rdat1_q <= '0;
            rdat2_q <= '0;
            sext_q  <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
        end else begin
            ctl_q   <= ctl_d;
            npc_q   <= npc_d;
            rdat1_q <= rdat1_d;
            rdat2_q <= rdat2_d;
            sext_q  <= sext_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
        end
    end

    assign id_ex_wb         = ctl_q.wb;
    assign id_ex_m          = ctl_q.m;
    assign id_ex_ex         = ctl_q.ex;
    assign id_ex_npc        = npc_q;
    assign id_ex_readdat1   = rdat1_q;
    assign id_ex_readdat2   = rdat2_q;
    assign id_ex_sign_ext   = sext_q;
    assign id_ex_instr_2016 = rt_q;
    assign id_ex_instr_1511 = rd_q;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed sequence then randomized cycles against a behavioural model.
// Honours REGFILE_BYPASS_EN the same way as the design build.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_id_instr = '0;
    logic [31:0] if_id_npc = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        mem_wb_regwrite = 1'b0;
    logic [4:0]  mem_wb_writereg = '0;
    logic [31:0] wb_writedata = '0;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_m;
    logic [3:0]  id_ex_ex;
    logic [31:0] id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext;
    logic [4:0]  id_ex_instr_2016, id_ex_instr_1511;

    id_stage dut (
        .clk(clk), .rst(rst), .if_id_instr(if_id_instr), .if_id_npc(if_id_npc),
        .stall(stall), .flush(flush), .mem_wb_regwrite(mem_wb_regwrite),
        .mem_wb_writereg(mem_wb_writereg), .wb_writedata(wb_writedata),
        .id_ex_wb(id_ex_wb), .id_ex_m(id_ex_m), .id_ex_ex(id_ex_ex),
        .id_ex_npc(id_ex_npc), .id_ex_readdat1(id_ex_readdat1),
        .id_ex_readdat2(id_ex_readdat2), .id_ex_sign_ext(id_ex_sign_ext),
        .id_ex_instr_2016(id_ex_instr_2016), .id_ex_instr_1511(id_ex_instr_1511)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] npc, r1, r2, se;
        logic [4:0]  rt, rd;
        bit          dc;   // control fields of the all-zero word are not compared
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [31:0] mreg [32];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
        end
    endtask

    // Monitor: the latch updates every posedge, so one expectation is retired per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (!e.dc) begin
                    chk("wb", {30'd0, id_ex_wb}, {30'd0, e.wb});
                    chk("m",  {29'd0, id_ex_m},  {29'd0, e.m});
                    chk("ex", {28'd0, id_ex_ex}, {28'd0, e.ex});
                end
                chk("npc", id_ex_npc, e.npc);
                chk("readdat1", id_ex_readdat1, e.r1);
                chk("readdat2", id_ex_readdat2, e.r2);
                chk("sign_ext", id_ex_sign_ext, e.se);
                chk("rt", {27'd0, id_ex_instr_2016}, {27'd0, e.rt});
                chk("rd", {27'd0, id_ex_instr_1511}, {27'd0, e.rd});
            end
        end
    end

    task automatic cyc(input bit r, input bit f, input bit s, input logic [31:0] ins,
                       input logic [31:0] np, input bit we, input logic [4:0] wr,
                       input logic [31:0] wd);
        logic [31:0] v1, v2;
        logic [4:0]  rs, rt;
        @(negedge clk); #1;
        rst = r; flush = f; stall = s; if_id_instr = ins; if_id_npc = np;
        mem_wb_regwrite = we; mem_wb_writereg = wr; wb_writedata = wd;
        if (r) begin
            cur = '{default: 0};
            for (int i = 0; i < 32; i++) mreg[i] = '0;
        end else begin
            rs = ins[25:21];
            rt = ins[20:16];
            v1 = (rs == 0) ? 32'd0 : mreg[rs];
            v2 = (rt == 0) ? 32'd0 : mreg[rt];
`ifdef REGFILE_BYPASS_EN
            if (we && wr != 0 && wr == rs) v1 = wd;
            if (we && wr != 0 && wr == rt) v2 = wd;
`endif
            if (f || !s) begin
                cur.npc = np; cur.r1 = v1; cur.r2 = v2;
                cur.se = {{16{ins[15]}}, ins[15:0]};
                cur.rt = rt; cur.rd = ins[15:11];
                cur.wb = 0; cur.m = 0; cur.ex = 0; cur.dc = 0;
                if (!f) begin
                    cur.dc = (ins == 32'd0);
                    case (ins[31:26])
                        6'b000000: begin cur.wb = 2'b10; cur.m = 3'b000; cur.ex = 4'b1100; end
                        6'b100011: begin cur.wb = 2'b11; cur.m = 3'b010; cur.ex = 4'b0001; end
                        6'b101011: begin cur.wb = 2'b00; cur.m = 3'b001; cur.ex = 4'b0001; end
                        6'b000100: begin cur.wb = 2'b00; cur.m = 3'b100; cur.ex = 4'b0010; end
                        default: ;
                    endcase
                end
            end
            if (we && wr != 0) mreg[wr] = wd;
        end
        q.push_back(cur);
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] ins;
        logic [5:0]  ops [5];
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2b; ops[3] = 6'h04; ops[4] = 6'h3f;

        cyc(1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        cyc(1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        cyc(0, 0, 0, 32'hFC000000, 32'h4, 1, 5'd5, 32'hDEADBEEF);
        cyc(0, 0, 0, 32'h00A53020, 32'h4, 0, 0, 0);
        cyc(0, 0, 0, 32'h8C22FFFC, 32'h8, 0, 0, 0);
        cyc(0, 0, 0, 32'h00001020, 32'hC, 1, 5'd0, 32'h12345678);
        cyc(0, 0, 0, 32'h00001020, 32'h10, 0, 0, 0);
        cyc(0, 0, 0, 32'h00E74020, 32'h14, 1, 5'd7, 32'hA5A5A5A5);
        cyc(0, 0, 0, 32'h00E74020, 32'h18, 0, 0, 0);
        cyc(0, 0, 1, 32'h1043000A, 32'h1C, 0, 0, 0);
        cyc(0, 1, 0, 32'h1043000A, 32'h20, 0, 0, 0);
        cyc(0, 0, 0, 32'h1043000A, 32'h24, 0, 0, 0);
        cyc(0, 0, 0, 32'hFC000000, 32'h28, 0, 0, 0);
        cyc(0, 0, 0, 32'h00000000, 32'h2C, 1, 5'd0, 32'hFFFFFFFF);
        cyc(0, 0, 0, 32'h00000000, 32'h30, 0, 0, 0);
        cyc(0, 0, 1, 32'h00000000, 32'h34, 1, 5'd9, 32'h0BADF00D);
        cyc(0, 1, 1, 32'h01200000, 32'h38, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            op  = ops[$urandom_range(0, 4)];
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            if (op == 6'h3f) ins[31:26] = 6'($urandom);
            cyc(($urandom % 60) == 0, ($urandom % 8) == 0, ($urandom % 6) == 0, ins, $urandom,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        end

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
